// File: rtl/led_fade_driver.sv
// PWM LED driver that ramps each channel's brightness linearly between off and
// full on, following on/off requests from the upstream PIO out_port.
module led_fade_driver #(
  parameter int NUM_LEDS = 2,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_LEDS-1:0]          led_in,
  input  logic                         fade_en,
  output logic [NUM_LEDS-1:0]          led_out,
  output logic                         busy,
  output logic [2*NUM_LEDS-1:0]        dbg_state_o,
  output logic [NUM_LEDS*PWM_BITS-1:0] dbg_level_o
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_e;

  logic [NUM_LEDS-1:0] led_in_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic                tick;
  state_e              state_q [NUM_LEDS];
  state_e              state_d [NUM_LEDS];
  logic [PWM_BITS-1:0] level_q [NUM_LEDS];
  logic [PWM_BITS-1:0] level_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic                busy_q, busy_d;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  // Per-channel ramp FSM. A direction change consumes its cycle, so a tick that
  // coincides with it leaves the level untouched. Saturation guards cover
  // reversals that happen at an endpoint level.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
      if (!fade_en) begin
        state_d[i] = led_in_q[i] ? S_ON : S_OFF;
        level_d[i] = led_in_q[i] ? MAX : '0;
      end else begin
        case (state_q[i])
          S_OFF: begin
            level_d[i] = '0;
            if (led_in_q[i]) state_d[i] = S_UP;
          end
          S_UP: begin
            if (!led_in_q[i]) begin
              state_d[i] = S_DOWN;
            end else if (tick) begin
              if (level_q[i] >= MAX - ONE) begin
                state_d[i] = S_ON;
                level_d[i] = MAX;
              end else begin
                level_d[i] = level_q[i] + ONE;
              end
            end
          end
          S_ON: begin
            level_d[i] = MAX;
            if (!led_in_q[i]) state_d[i] = S_DOWN;
          end
          default: begin
            if (led_in_q[i]) begin
              state_d[i] = S_UP;
            end else if (tick) begin
              if (level_q[i] <= ONE) begin
                state_d[i] = S_OFF;
                level_d[i] = '0;
              end else begin
                level_d[i] = level_q[i] - ONE;
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    led_out_d   = '0;
    busy_d      = 1'b0;
    dbg_state_o = '0;
    dbg_level_o = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (level_q[i] == MAX)     led_out_d[i] = 1'b1;
      else if (level_q[i] != '0) led_out_d[i] = (pwm_q < level_q[i]);
      if (state_q[i] == S_UP || state_q[i] == S_DOWN) busy_d = 1'b1;
      dbg_state_o[2*i +: 2]               = state_q[i];
      dbg_level_o[PWM_BITS*i +: PWM_BITS] = level_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_in_q  <= '0;
      pre_q     <= '0;
      pwm_q     <= '0;
      led_out_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= S_OFF;
        level_q[i] <= '0;
      end
    end else begin
      led_in_q  <= led_in;
      pre_q     <= pre_d;
      pwm_q     <= pwm_q + ONE;
      led_out_q <= led_out_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Consumer stage that sits directly downstream of the Avalon-MM LED PIO.
- Takes the PIO's registered out_port bits as on/off requests per LED.
- Drives the physical LED pins with a PWM signal whose brightness ramps linearly up on turn-on and down on turn-off.
- Same clock domain as the PIO; no Avalon interface of its own.

Parameters:
- NUM_LEDS, 2, number of LED channels (matches PIO out_port width).
- PWM_BITS, 8, width of the brightness level and PWM counter; MAX = 2^PWM_BITS-1.
- STEP_DIV, 1024, clocks per brightness step; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- led_in  input  NUM_LEDS  on/off request per LED, from the PIO out_port.
- fade_en  input  1  1 = ramped transitions; 0 = immediate on/off.
- led_out  output  NUM_LEDS  PWM drive to the LED pins, active high, registered.
- busy  output  1  high while any channel is in UP or DOWN, registered.

Behaviour:
- Reset: one clock domain, clk; reset is synchronous and active-low (reset_n sampled on the rising edge of clk). On reset_n=0 at a clock edge:
  - all channels go to OFF with level=0;
  - led_in_q, prescaler, pwm_cnt, led_out and busy are all cleared to 0.
  - Reset mid-ramp aborts immediately; there is no ramp-down on reset.
- Input stage: led_in_q <= led_in every clock. All state decisions use led_in_q, giving 1 cycle of input latency.
- Prescaler:
  - counts 0..STEP_DIV-1 and wraps;
  - tick=1 for exactly one cycle when prescaler==STEP_DIV-1;
  - free-running from reset and independent of channel state.
- PWM counter: pwm_cnt is PWM_BITS wide, increments every clock, wraps MAX->0.
- Per-channel FSM. States OFF, UP, ON, DOWN; level is PWM_BITS unsigned.
  - OFF: level=0. led_in_q=1 -> UP.
  - UP:
    - led_in_q=0 -> DOWN, with level held (no jump).
    - Otherwise on tick, level+1. If level+1==MAX -> ON.
  - ON: level=MAX. led_in_q=0 -> DOWN.
  - DOWN:
    - led_in_q=1 -> UP, with level held.
    - Otherwise on tick, level-1. If level-1==0 -> OFF.
  - Direction change and tick in the same cycle: the transition wins and level is not modified that cycle.
  - Level never wraps; saturation is guaranteed by the transitions above.
- fade_en=0 overrides the FSM, effective the same cycle it is sampled:
  - led_in_q=1 -> state ON, level=MAX;
  - led_in_q=0 -> state OFF, level=0.
  - Toggling fade_en to 0 mid-ramp snaps to the endpoint. Toggling it back to 1 resumes normal FSM operation from ON/OFF.
- Output (registered, 1 cycle after level/pwm_cnt):
  - level==0 -> led_out[i]=0;
  - level==MAX -> led_out[i]=1 constantly (100% duty);
  - otherwise led_out[i] = (pwm_cnt < level). Duty is level/2^PWM_BITS.
- busy <= OR over channels of (state==UP or state==DOWN).
- Channels are fully independent and share only the prescaler and pwm_cnt.
- Total ramp: MAX ticks, i.e. (MAX-1)*STEP_DIV+1 .. MAX*STEP_DIV clocks depending on prescaler phase.

Test Plan (PWM_BITS=4, STEP_DIV=4, NUM_LEDS=2 unless noted):
- Reset hold → release with led_in=00, fade_en=1 → led_out=00 and busy=0 for 200 cycles; pwm_cnt wraps 15->0 every 16 cycles.
- led_in=01 at cycle 10:
  - busy rises 2 cycles later;
  - channel 0 level increments by 1 on every tick (every 4 clocks) and reaches 15 after 15 ticks;
  - busy then falls and led_out[0] stays constant 1;
  - led_out[1]=0 throughout.
- Ramp check at level=8: measured over 16 cycles, led_out[0] is high for exactly 8 cycles.
- Reversal: led_in=01 until level=5, then 00:
  - next state is DOWN with level still 5;
  - level steps 4,3,2,1,0 on subsequent ticks, then state OFF and busy=0;
  - no tick is lost or doubled at the reversal cycle.
- fade_en=0 with led_in=11 → both levels=15 within 2 cycles of the led_in change; led_out=11 one cycle later; busy never asserts.
- Reset mid-ramp (level=7, state UP), reset_n=0 for 1 cycle:
  - next cycle level=0, led_out=00, busy=0, prescaler=0;
  - with led_in still 01, ramp restarts from 0 after reset release.
